// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling and 2-of-3 mid-bit voting.
// Each received byte is held in a one-entry valid/ready output register.
// Ports:
//   clk, rst_n       - system clock, asynchronous active-low reset
//   clken            - global enable; only the rxd synchronizer runs while low
//   baud_x16_strobe  - one-clk pulse at 16x the baud rate
//   rxd              - asynchronous serial input, idle high
//   data, valid      - received byte and its valid flag
//   ready            - consumer accepts data when high together with valid
//   framing_error    - one-clk pulse when the stop bit is sampled low
//   overrun          - one-clk pulse when a byte completes while valid is high
module uart_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clken,
    input  logic       baud_x16_strobe,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int unsigned PhW   = 4;
    localparam int unsigned DataW = 8;
    localparam int unsigned IdxW  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    logic             rxd_meta_q;
    logic             rxd_s_q;

    state_e           state_q, state_d;
    logic [PhW-1:0]   ph_q, ph_d;
    logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
    logic [DataW-1:0] shift_q, shift_d;
    logic [1:0]       smp_q, smp_d;

    logic [DataW-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    logic             tick_c;
    logic             mid_c;
    logic             maj_c;
    logic             deliver_c;
    logic             stop_err_c;
    logic             accept_c;

    // Two-flop synchronizer; runs every clk regardless of clken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    assign tick_c = clken & baud_x16_strobe;
    assign mid_c  = (ph_q == PhW'(9));
    // Phase-9 sample is the live synchronizer output, phases 7 and 8 are stored.
    assign maj_c  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s_q) | (smp_q[1] & rxd_s_q);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            smp_q     <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            smp_q     <= smp_d;
        end
    end

    // FSM next-state and datapath update; everything advances only on ticks.
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        smp_d     = smp_q;
        if (tick_c) begin
            if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
                ph_d = ph_q + PhW'(1);
                if (ph_q == PhW'(7)) smp_d[0] = rxd_s_q;
                if (ph_q == PhW'(8)) smp_d[1] = rxd_s_q;
            end
            case (state_q)
                S_IDLE: begin
                    // The detect tick counts as phase 0.
                    if (!rxd_s_q) begin
                        state_d = S_START;
                        ph_d    = PhW'(1);
                    end
                end
                S_START: begin
                    if (mid_c && maj_c) begin
                        state_d = S_IDLE;
                        ph_d    = '0;
                    end else if (ph_q == PhW'(15)) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end
                end
                S_DATA: begin
                    if (mid_c) shift_d = {maj_c, shift_q[DataW-1:1]};
                    if (ph_q == PhW'(15)) begin
                        if (bit_idx_q == IdxW'(7)) state_d = S_STOP;
                        else bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end
                S_STOP: begin
                    // Leave at mid-stop so a following start edge is not missed.
                    if (mid_c) begin
                        ph_d    = '0;
                        state_d = maj_c ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (rxd_s_q) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    ph_d    = '0;
                end
            endcase
        end
    end

    // Output decode: delivery, error pulses and the output-register handshake.
    always_comb begin
        deliver_c  = tick_c && (state_q == S_STOP) && mid_c && maj_c;
        stop_err_c = tick_c && (state_q == S_STOP) && mid_c && !maj_c;
        accept_c   = clken && valid_q && ready;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = stop_err_c;
        ovr_d      = 1'b0;
        if (deliver_c) begin
            if (!valid_q || accept_c) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept_c) begin
            valid_d = 1'b0;
        end
    end

    // Output registers; error pulses clear on the following clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data          = data_q;
    assign valid         = valid_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Frames are generated from the
// 8N1 bit sequence; each expected byte and its delivery tick are queued when
// the frame starts, and a negedge monitor checks deliveries and error pulses.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clken = 1'b1;
    logic       baud_x16_strobe = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       overrun;

    uart_rx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clken           (clken),
        .baud_x16_strobe (baud_x16_strobe),
        .rxd             (rxd),
        .data            (data),
        .valid           (valid),
        .ready           (ready),
        .framing_error   (framing_error),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         t;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         tick_no = 0;
    int         sc = 0;
    int         fe_seen = 0;
    int         ov_seen = 0;
    int         exp_fe = 0;
    int         exp_ov = 0;
    int         frame_t0 = 0;
    logic       valid_prev = 1'b0;
    logic       acc_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    // Baud generator: one strobe every 16 enabled clocks, frozen while clken is low.
    always @(negedge clk) begin
        if (clken) begin
            sc = (sc + 1) % 16;
            baud_x16_strobe = (sc == 0);
        end
    end

    always @(posedge clk) begin
        if (clken && baud_x16_strobe) tick_no <= tick_no + 1;
    end

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, expv, $time);
    endtask

    // Monitor: error pulse counting, delivery latency, handshake and data checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            valid_prev = 1'b0;
            acc_prev   = 1'b0;
        end else begin
            if (framing_error) fe_seen++;
            if (overrun) ov_seen++;
            if (valid_prev && !acc_prev) begin
                check("valid_held", int'(valid), 1);
                check("data_stable", int'(data), int'(data_prev));
            end
            if (valid && !valid_prev) begin
                if (q.size() == 0) check("valid_with_empty_queue", q.size(), 1);
                else check("valid_rise_tick", tick_no, q[0].t);
            end
            if (valid && ready && clken) begin
                if (q.size() == 0) begin
                    check("accept_with_empty_queue", q.size(), 1);
                end else begin
                    check("rx_data", int'(data), int'(q[0].d));
                    void'(q.pop_front());
                end
            end
            valid_prev = valid;
            acc_prev   = valid && ready && clken;
            data_prev  = data;
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (!(clken && baud_x16_strobe));
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
        #1;
    endtask

    // Drive one 8N1 frame starting just after a tick edge; a frame with a bad
    // stop bit leaves rxd low afterwards. Delivery is due 154 ticks after the
    // tick preceding the start edge (detect tick + 9*16 + 9).
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic ovr);
        logic [9:0] bits;
        bits     = {stop, b, 1'b0};
        frame_t0 = tick_no;
        if (!stop) exp_fe++;
        else if (ovr) exp_ov++;
        else q.push_back('{d: b, t: frame_t0 + 154});
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            wait_ticks(16);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_queue_empty"}, q.size(), 0);
        check({name, "_fe_count"}, fe_seen, exp_fe);
        check({name, "_ov_count"}, ov_seen, exp_ov);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(valid), 0);
        check("reset_data", int'(data), 0);
        check("reset_fe", int'(framing_error), 0);
        check("reset_ov", int'(overrun), 0);
        rst_n = 1'b1;
        wait_ticks(4);

        // Plain byte with the consumer always ready.
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_ticks(4);
        check_idle("a5");

        // Five-tick low glitch, then a frame right after the false-start decision.
        rxd = 1'b0;
        wait_ticks(5);
        rxd = 1'b1;
        wait_ticks(5);
        send_frame(8'h5C, 1'b1, 1'b0);
        wait_ticks(4);
        check_idle("glitch");

        // Bad stop bit, line held low, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(40);
        rxd = 1'b1;
        wait_ticks(2);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_ticks(4);
        check_idle("framing");

        // Overrun: second back-to-back byte arrives while the first is unread.
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        wait_ticks(2);
        check("ovr_valid", int'(valid), 1);
        check("ovr_data", int'(data), 'h11);
        check("ovr_count", ov_seen, exp_ov);
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ovr_drained_valid", int'(valid), 0);
        check_idle("overrun");

        // Consumer accepts on the very edge a new byte is delivered.
        ready = 1'b0;
        send_frame(8'h33, 1'b1, 1'b0);
        fork
            send_frame(8'h44, 1'b1, 1'b0);
            begin
                repeat (153) wait_tick();
                repeat (15) @(posedge clk);
                #1;
                ready = 1'b1;
            end
        join
        wait_ticks(2);
        check("same_edge_valid", int'(valid), 0);
        check_idle("same_edge");

        // Reset during data bit 3 while an unread byte is held.
        ready = 1'b0;
        send_frame(8'hC3, 1'b1, 1'b0);
        rxd = 1'b0;
        wait_ticks(16);
        rxd = 1'b1;
        wait_ticks(48);
        rxd = 1'b0;
        wait_ticks(5);
        check("pre_reset_data", int'(data), 'hC3);
        rst_n = 1'b0;
        rxd   = 1'b1;
        #1;
        check("midreset_valid", int'(valid), 0);
        check("midreset_data", int'(data), 0);
        check("midreset_fe", int'(framing_error), 0);
        check("midreset_ov", int'(overrun), 0);
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        wait_ticks(30);
        check("post_reset_quiet", int'(valid), 0);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_ticks(4);
        check_idle("reset");

        // clken low for 100 clocks mid-frame; delivery tick must not move.
        fork
            send_frame(8'h96, 1'b1, 1'b0);
            begin
                wait_ticks(70);
                clken = 1'b0;
                repeat (100) @(negedge clk);
                check("paused_valid", int'(valid), 0);
                clken = 1'b1;
            end
        join
        wait_ticks(4);
        check_idle("clken");

        // Random bytes, occasional bad stop bits, random idle gaps.
        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop, 1'b0);
            if (!stop) begin
                wait_ticks($urandom_range(0, 30));
                rxd = 1'b1;
                wait_ticks(1);
            end
            wait_ticks($urandom_range(0, 3));
        end
        wait_ticks(4);
        check_idle("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
